// File: rtl/aes_pkg.sv
// AES-128 shared constants and types: S-box table, round constants, word/block types.
// Latency: n/a (package only).
// Backpressure: n/a.
package aes_pkg;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Schedule blocks are held w0-first; the datapath wants the last word first.
    function automatic aes_block_t word_rev(input aes_block_t b);
        return {b[31:0], b[63:32], b[95:64], b[127:96]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES S-box lookup, shared with the cipher datapath.
// Latency: combinational.
// Backpressure: none.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/key_gen_round.sv
// One AES-128 key-expansion step: four schedule words in, next four out (w0-first order).
// Latency: combinational.
// Backpressure: none.
module key_gen_round
    import aes_pkg::*;
#(
    parameter int unsigned RND = 1
) (
    input  aes_block_t prev_key,
    output aes_block_t next_key
);

    aes_word_t p0, p1, p2, p3;
    aes_word_t rot_w, sub_w;
    aes_word_t n0, n1, n2, n3;

    assign {p0, p1, p2, p3} = prev_key;
    assign rot_w = {p3[23:0], p3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sub
        aes_sbox u_sbox (
            .in_byte  (rot_w[8*b +: 8]),
            .out_byte (sub_w[8*b +: 8])
        );
    end

    assign n0 = p0 ^ sub_w ^ {RCON[RND], 24'h0};
    assign n1 = p1 ^ n0;
    assign n2 = p2 ^ n1;
    assign n3 = p3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/key_gen.sv
// AES-128 key schedule: fully unrolled expansion, round key selected by round index.
// Latency: 0 cycles; 1 cycle with KEYGEN_OUT_REG_EN (output register, async clear).
// Backpressure: none; output tracks keyIn/round continuously.
module key_gen
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] keyIn,
    input  logic [3:0]   round,
    output logic [127:0] roundKey
);

    aes_block_t key1, key2, key3, key4, key5, key6, key7, key8, key9, key10;
    aes_block_t key_sel;

    key_gen_round #(.RND(1))  u_rnd1  (.prev_key(keyIn), .next_key(key1));
    key_gen_round #(.RND(2))  u_rnd2  (.prev_key(key1),  .next_key(key2));
    key_gen_round #(.RND(3))  u_rnd3  (.prev_key(key2),  .next_key(key3));
    key_gen_round #(.RND(4))  u_rnd4  (.prev_key(key3),  .next_key(key4));
    key_gen_round #(.RND(5))  u_rnd5  (.prev_key(key4),  .next_key(key5));
    key_gen_round #(.RND(6))  u_rnd6  (.prev_key(key5),  .next_key(key6));
    key_gen_round #(.RND(7))  u_rnd7  (.prev_key(key6),  .next_key(key7));
    key_gen_round #(.RND(8))  u_rnd8  (.prev_key(key7),  .next_key(key8));
    key_gen_round #(.RND(9))  u_rnd9  (.prev_key(key8),  .next_key(key9));
    key_gen_round #(.RND(10)) u_rnd10 (.prev_key(key9),  .next_key(key10));

    // Round 0 passes the key through in its original word order; later rounds are word-reversed.
    always_comb begin
        key_sel = '0;
        case (round)
            4'd0:    key_sel = keyIn;
            4'd1:    key_sel = word_rev(key1);
            4'd2:    key_sel = word_rev(key2);
            4'd3:    key_sel = word_rev(key3);
            4'd4:    key_sel = word_rev(key4);
            4'd5:    key_sel = word_rev(key5);
            4'd6:    key_sel = word_rev(key6);
            4'd7:    key_sel = word_rev(key7);
            4'd8:    key_sel = word_rev(key8);
            4'd9:    key_sel = word_rev(key9);
            4'd10:   key_sel = word_rev(key10);
            default: key_sel = '0;
        endcase
    end

`ifdef KEYGEN_OUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            roundKey <= '0;
        end else begin
            roundKey <= key_sel;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign roundKey = key_sel;
`endif

endmodule

// File: tb/tb_key_gen.sv
// Directed self-checking bench for key_gen; works for both the combinational and registered builds.
module tb_key_gen;

`ifdef KEYGEN_OUT_REG_EN
    localparam bit REG_BUILD = 1'b1;
`else
    localparam bit REG_BUILD = 1'b0;
`endif

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R5_A  = 128'h11f915bccaf2b8bc7c839d87d4d1c6f8;
    localparam logic [127:0] R10_A = 128'hb6630ca6e13f0cc8c9ee2589d014f9a8;
    localparam logic [127:0] R10_Z = 128'h6f8f188e23e951cf3e92e211b4ef5bcb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] keyIn = '0;
    logic [3:0]   round = '0;
    logic [127:0] roundKey;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   rnd;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [16];

    key_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .keyIn    (keyIn),
        .round    (round),
        .roundKey (roundKey)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Drive just after posedge; sample at the negedge where the key is due.
    task automatic apply(input logic [127:0] k, input logic [3:0] r);
        @(posedge clk);
        #1;
        keyIn = k;
        round = r;
        if (REG_BUILD) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{KEY_A, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1]  = '{KEY_A, 4'd1,  128'h2a6c760523a3393988542cb1a0fafe17};
        vecs[2]  = '{KEY_A, 4'd2,  128'h7359f67f5935807a7a96b943f2c295f2};
        vecs[3]  = '{KEY_A, 4'd3,  128'h6d7a883b1e237e444716fe3e3d80477d};
        vecs[4]  = '{KEY_A, 4'd4,  128'hdb0bad00b671253ba8525b7fef44a541};
        vecs[5]  = '{KEY_A, 4'd5,  R5_A};
        vecs[6]  = '{KEY_A, 4'd6,  128'hca0093fddbf98641110b3efd6d88a37a};
        vecs[7]  = '{KEY_A, 4'd7,  128'h4ea6dc4f84a64fb25f5fc9f34e54f70e};
        vecs[8]  = '{KEY_A, 4'd8,  128'h7f8d292f312bf560b58dbad2ead27321};
        vecs[9]  = '{KEY_A, 4'd9,  128'h575c006e28d1294119fadc21ac7766f3};
        vecs[10] = '{KEY_A, 4'd10, R10_A};
        vecs[11] = '{KEY_A, 4'd11, 128'h0};
        vecs[12] = '{KEY_A, 4'd15, 128'h0};
        vecs[13] = '{128'h0, 4'd1, 128'h62636363626363636263636362636363};
        vecs[14] = '{128'h0, 4'd2, 128'hf9fbfbaa9b9898c9f9fbfbaa9b9898c9};
        vecs[15] = '{{128{1'b1}}, 4'd1, 128'h17161616e8e9e9e917161616e8e9e9e9};

        // Reset state: registered output is cleared; combinational output ignores reset.
        keyIn = KEY_A;
        round = 4'd0;
        repeat (2) @(negedge clk);
        check("reset_state", roundKey, REG_BUILD ? 128'h0 : KEY_A);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].key, vecs[i].rnd);
            check($sformatf("vec%0d_r%0d", i, vecs[i].rnd), roundKey, vecs[i].exp);
        end

        // Key change while round 10 is held.
        apply(KEY_A, 4'd10);
        check("hold_r10_keyA", roundKey, R10_A);
        @(posedge clk);
        #1;
        keyIn = 128'h0;
        if (REG_BUILD) begin
            #1;
            check("hold_r10_before_edge", roundKey, R10_A);
            @(posedge clk);
        end
        @(negedge clk);
        check("hold_r10_keyZ", roundKey, R10_Z);

        // Reset mid-sweep at round 5.
        apply(KEY_A, 4'd5);
        check("pre_reset_r5", roundKey, R5_A);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_immediate", roundKey, REG_BUILD ? 128'h0 : R5_A);
        @(posedge clk);
        @(negedge clk);
        check("reset_held", roundKey, REG_BUILD ? 128'h0 : R5_A);
        rst_n = 1'b1;
        #1;
        check("release_before_edge", roundKey, REG_BUILD ? 128'h0 : R5_A);
        @(posedge clk);
        @(negedge clk);
        check("release_r5", roundKey, R5_A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
